// File: rtl/rr_hold_arbiter.sv
// rtl/rr_hold_arbiter.sv - round-robin arbiter whose winner holds the grant until done, request drop or hold limit
// Grant, owner index, priority pointer and hold counter are all registered so the outputs stay mutually consistent.

module rr_hold_arbiter #(
    parameter int REQS     = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = $clog2(REQS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [REQS-1:0] reqs_i,
    input  logic [REQS-1:0] done_i,
    output logic [REQS-1:0] grants_o,
    output logic            any_grant_o,
    output logic [IDW-1:0]  grant_id_o,
    output logic            timeout_o
);

    localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [IDW-1:0] LAST_IDX  = IDW'(REQS - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    logic [0:0]      state_q,     state_d;
    logic [REQS-1:0] grants_q,    grants_d;
    logic            any_grant_q, any_grant_d;
    logic [IDW-1:0]  grant_id_q,  grant_id_d;
    logic [IDW-1:0]  ptr_q,       ptr_d;
    logic [HCW-1:0]  hcnt_q,      hcnt_d;
    logic            timeout_q,   timeout_d;

    logic            owner_done;
    logic            owner_req;
    logic            expired;
    logic            release_now;
    logic [IDW-1:0]  next_ptr;
    logic [IDW-1:0]  arb_ptr;
    logic            arb_found;
    logic [IDW-1:0]  arb_win;

    // Scan req starting at p, wrapping at REQS; returns {found, index}.
    function automatic logic [IDW:0] rr_pick(input logic [REQS-1:0] req,
                                             input logic [IDW-1:0]  p);
        logic [IDW:0]   idx;
        logic           found;
        logic [IDW-1:0] win;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < REQS; k++) begin
            idx = {1'b0, p} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(REQS)) begin
                idx = idx - (IDW+1)'(REQS);
            end
            if (!found && req[idx[IDW-1:0]]) begin
                found = 1'b1;
                win   = idx[IDW-1:0];
            end
        end
        return {found, win};
    endfunction

    always_comb begin
        owner_done  = done_i[grant_id_q];
        owner_req   = reqs_i[grant_id_q];
        expired     = (hcnt_q == HOLD_LAST);
        release_now = (state_q == ST_OWNED) && (owner_done || !owner_req || expired);
        next_ptr    = (grant_id_q == LAST_IDX) ? '0 : grant_id_q + IDW'(1);
        // On release the new pointer is used in the same cycle so the handoff has no bubble.
        arb_ptr     = release_now ? next_ptr : ptr_q;
        {arb_found, arb_win} = rr_pick(reqs_i, arb_ptr);
    end

    always_comb begin
        state_d    = state_q;
        grants_d   = grants_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        hcnt_d     = hcnt_q;
        timeout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    state_d    = ST_OWNED;
                    grants_d   = REQS'(1) << arb_win;
                    grant_id_d = arb_win;
                    hcnt_d     = '0;
                end
            end
            ST_OWNED: begin
                if (!release_now) begin
                    hcnt_d = hcnt_q + HCW'(1);
                end else begin
                    ptr_d     = next_ptr;
                    timeout_d = expired && !owner_done && owner_req;
                    hcnt_d    = '0;
                    if (arb_found) begin
                        grants_d   = REQS'(1) << arb_win;
                        grant_id_d = arb_win;
                    end else begin
                        state_d    = ST_IDLE;
                        grants_d   = '0;
                        grant_id_d = '0;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grants_d   = '0;
                grant_id_d = '0;
                hcnt_d     = '0;
            end
        endcase

        any_grant_d = |grants_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grants_q    <= '0;
            any_grant_q <= 1'b0;
            grant_id_q  <= '0;
            ptr_q       <= '0;
            hcnt_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grants_q    <= grants_d;
            any_grant_q <= any_grant_d;
            grant_id_q  <= grant_id_d;
            ptr_q       <= ptr_d;
            hcnt_q      <= hcnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign grants_o    = grants_q;
    assign any_grant_o = any_grant_q;
    assign grant_id_o  = grant_id_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// tb/tb_rr_hold_arbiter.sv - directed and randomized checks of rr_hold_arbiter against an integer reference model

module tb_rr_hold_arbiter;

    localparam int REQS     = 4;
    localparam int MAX_HOLD = 4;
    localparam int IDW      = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [REQS-1:0] reqs_i = '0;
    logic [REQS-1:0] done_i = '0;
    logic [REQS-1:0] grants_o;
    logic            any_grant_o;
    logic [IDW-1:0]  grant_id_o;
    logic            timeout_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: owner is -1 when nobody holds the resource, held counts cycles 1..MAX_HOLD.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    int m_to    = 0;

    rr_hold_arbiter #(.REQS(REQS), .MAX_HOLD(MAX_HOLD), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .reqs_i     (reqs_i),
        .done_i     (done_i),
        .grants_o   (grants_o),
        .any_grant_o(any_grant_o),
        .grant_id_o (grant_id_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [REQS-1:0] r, input int p);
        for (int k = 0; k < REQS; k++) begin
            if (r[(p + k) % REQS]) return (p + k) % REQS;
        end
        return -1;
    endfunction

    function automatic logic [REQS-1:0] model_grants();
        logic [REQS-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_edge();
        int o;
        bit expired;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_to = 0;
        end else if (m_owner < 0) begin
            m_to = 0;
            m_owner = pick(reqs_i, m_ptr);
            m_held = (m_owner >= 0) ? 1 : 0;
        end else begin
            o = m_owner;
            expired = (m_held == MAX_HOLD);
            if (!done_i[o] && reqs_i[o] && !expired) begin
                m_held++;
                m_to = 0;
            end else begin
                m_to = (expired && !done_i[o] && reqs_i[o]) ? 1 : 0;
                m_ptr = (o + 1) % REQS;
                m_owner = pick(reqs_i, m_ptr);
                m_held = (m_owner >= 0) ? 1 : 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".grants"},  32'(grants_o),    32'(model_grants()));
        check({tag, ".any"},     32'(any_grant_o), 32'(m_owner >= 0));
        check({tag, ".id"},      32'(grant_id_o),  32'((m_owner >= 0) ? m_owner : 0));
        check({tag, ".timeout"}, 32'(timeout_o),   32'(m_to));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic expect_out(input string tag, input logic [REQS-1:0] g, input logic to);
        check({tag, ".grants_exp"},  32'(grants_o),  32'(g));
        check({tag, ".timeout_exp"}, 32'(timeout_o), 32'(to));
    endtask

    initial begin
        logic [REQS-1:0] seq [4];
        seq[0] = 4'b0010; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'b0001;

        // Reset held with all requests active.
        rst = 1'b1; reqs_i = 4'b1111; done_i = '0;
        for (int i = 0; i < 3; i++) begin
            step("reset");
            expect_out("reset", 4'b0000, 1'b0);
            check("reset.any", 32'(any_grant_o), 32'd0);
            check("reset.id",  32'(grant_id_o),  32'd0);
        end
        rst = 1'b0;
        step("first_grant");
        expect_out("first_grant", 4'b0001, 1'b0);
        check("first_grant.id", 32'(grant_id_o), 32'd0);

        // Completion-driven rotation.
        for (int i = 0; i < 4; i++) begin
            done_i = grants_o;
            step("rotate");
            expect_out("rotate", seq[i], 1'b0);
        end

        // Forced releases after MAX_HOLD cycles.
        done_i = '0; reqs_i = 4'b0011;
        for (int i = 0; i < 3; i++) begin step("hold0"); expect_out("hold0", 4'b0001, 1'b0); end
        step("to1"); expect_out("to1", 4'b0010, 1'b1);
        for (int i = 0; i < 3; i++) begin step("hold1"); expect_out("hold1", 4'b0010, 1'b0); end
        step("to0"); expect_out("to0", 4'b0001, 1'b1);

        // Request drops, idle, and regrant from idle.
        reqs_i = 4'b0100; step("drop0");  expect_out("drop0", 4'b0100, 1'b0);
        reqs_i = 4'b1001; step("drop2");  expect_out("drop2", 4'b1000, 1'b0);
        reqs_i = 4'b0000; step("idle");   expect_out("idle", 4'b0000, 1'b0);
        check("idle.any", 32'(any_grant_o), 32'd0);
        step("idle2");    expect_out("idle2", 4'b0000, 1'b0);
        reqs_i = 4'b0100; step("regrant"); expect_out("regrant", 4'b0100, 1'b0);

        // Done in the same cycle as expiry suppresses the timeout pulse.
        reqs_i = 4'b0001; step("to_owner0"); expect_out("to_owner0", 4'b0001, 1'b0);
        reqs_i = 4'b0011;
        for (int i = 0; i < 3; i++) begin step("hold0b"); expect_out("hold0b", 4'b0001, 1'b0); end
        done_i = 4'b0001; step("done_exp"); expect_out("done_exp", 4'b0010, 1'b0);
        done_i = '0;

        // Reset in the middle of a grant.
        reqs_i = 4'b0100; step("to_owner2"); expect_out("to_owner2", 4'b0100, 1'b0);
        step("owner2_h1"); expect_out("owner2_h1", 4'b0100, 1'b0);
        rst = 1'b1; reqs_i = 4'b0101; step("mid_rst"); expect_out("mid_rst", 4'b0000, 1'b0);
        rst = 1'b0; step("post_rst"); expect_out("post_rst", 4'b0001, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 63) == 0);
            reqs_i = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) done_i = model_grants();
            else                           done_i = 4'($urandom) & 4'($urandom);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_hold_arbiter.md
# rr_hold_arbiter

Round-robin arbiter with grant locking. It shares one multi-cycle resource among `REQS` requesters: a winner keeps its grant until it signals completion, drops its request, or reaches a hold-time limit. Fairness comes from a rotating priority pointer. It sits in front of the shared datapath port that the existing single-cycle `rr_arbiter` cannot guard, because transactions there span several cycles.

## Interface
- `REQS`, default 4: number of requesters, ≥2.
- `MAX_HOLD`, default 8: maximum consecutive cycles one grant may be held, ≥1.
- `IDW`, default `$clog2(REQS)`: width of `grant_id_o`.

Ports:
- `clk`, input, 1: single clock; all state changes on rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `reqs_i`, input, REQS: request vector; bit i held high while requester i wants or is using the resource.
- `done_i`, input, REQS: bit i pulses high in a cycle where requester i owns the grant and finishes.
- `grants_o`, output, REQS: registered one-hot grant, or all-zero.
- `any_grant_o`, output, 1: registered; high exactly when `grants_o` != 0.
- `grant_id_o`, output, IDW: binary index of the owner; 0 when there is no grant.
- `timeout_o`, output, 1: registered one-cycle pulse flagging a forced release.

## Operation
- State is `grants_o`, the owner index, priority pointer `ptr` (IDW bits), hold counter `hcnt` (counts 0..MAX_HOLD-1), and `timeout_o`.
- Two-state FSM:
  - IDLE: `grants_o`=0.
  - OWNED: exactly one grant bit set.
- Arbitration function: first set bit of `reqs_i` found scanning `ptr`, `ptr+1`, … mod REQS.
- IDLE:
  - If `reqs_i`!=0, grant the arbitration winner, set `hcnt`=0, go to OWNED.
  - Otherwise stay in IDLE.
- OWNED, owner o, at each edge a release condition R is evaluated. R is any of:
  - `done_i[o]`.
  - `!reqs_i[o]`.
  - `hcnt`==MAX_HOLD-1.
- OWNED without R: keep the grant; `hcnt`++.
- OWNED with R:
  - Set `ptr` = (o+1) mod REQS.
  - Arbitrate immediately with the new `ptr` (back-to-back handoff, no idle bubble).
  - If a winner exists, grant it and set `hcnt`=0; otherwise go to IDLE.
  - The old owner competes again, but only wins when no other requester is active.
- `timeout_o` is set for one cycle after a release only when the release was caused solely by `hcnt` expiry. If `done_i[o]` or a request drop occurs in the same cycle as expiry, there is no timeout pulse.
- `done_i` bits of non-owners are ignored.
- `ptr` changes only on release; it does not move while IDLE.
- Pointer and index arithmetic wraps mod REQS. For non-power-of-2 REQS, `ptr` never exceeds REQS-1.
- Reset clears `grants_o`=0, `any_grant_o`=0, `grant_id_o`=0, `timeout_o`=0, `ptr`=0, `hcnt`=0, and state=IDLE.
- Reset overrides everything, including mid-grant: the grant is dropped in the cycle after the reset edge and requests present during reset are ignored.

## Timing
- Request-to-grant latency is 1 cycle: a request sampled high at edge N (state IDLE) gives `grants_o` high after edge N.
- Release latency is 1 cycle: a release condition sampled at edge N removes the old grant after edge N, and the new owner's grant appears at the same instant.
- A single grant lasts at least 1 and at most MAX_HOLD cycles.
- `any_grant_o`, `grant_id_o` and `grants_o` are mutually consistent every cycle, since all are registered from the same state.
- `timeout_o` is high in the first cycle of the state that follows a forced release.
- Worst-case wait for a continuously requesting requester is (REQS-1)·MAX_HOLD cycles before its grant.

## Test plan
All scenarios use REQS=4, MAX_HOLD=4.
- **Reset:** `rst`=1 with `reqs_i`=1111 for 3 cycles → all outputs 0. Release reset → `grants_o`=0001, `grant_id_o`=0 one cycle later.
- **Full rotation with completion:** `reqs_i`=1111 and `done_i`=`grants_o` → `grants_o` sequence 0001, 0010, 0100, 1000, 0001, one cycle each, with no bubbles and `timeout_o` always 0.
- **Timeout:** `reqs_i`=0011, `done_i`=0 → 0001 for 4 cycles, then 0010 for 4 cycles, then 0001. `timeout_o` pulses in the first cycle of each new grant.
- **Request drop and idle:**
  - Owner 2 drops its request with `reqs_i`=1001 → next grant 1000 (`ptr`=3).
  - Then `reqs_i`=0000 → `grants_o`=0000 and `any_grant_o`=0.
  - Then `reqs_i`=0100 → grant 0100 after 1 cycle.
- **Done coinciding with expiry:** owner 0 asserts `done_i`=0001 in its 4th held cycle with `reqs_i`=0011 → handoff to 0010 and `timeout_o` stays 0.
- **Reset mid-grant:** owner 2 at `hcnt`=1, `rst` pulsed for 1 cycle with `reqs_i`=0101 → `grants_o`=0 after the reset edge, then 0001 (`ptr` back at 0).
